// File: rtl/joy_conditioner.sv
// Joystick input conditioner: per-channel 2-flop synchroniser, debouncer and
// IDLE/HOLD/REPEAT strobe generator with optional auto-repeat.
module joy_conditioner #(
  parameter int             N               = 5,
  parameter int             DEBOUNCE_CYCLES = 500000,
  parameter int             REPEAT_DELAY    = 25000000,
  parameter int             REPEAT_PERIOD   = 5000000,
  parameter logic [N-1:0]   REPEAT_MASK     = 5'b01111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     joy_in,
  output logic [N-1:0]     joy_level,
  output logic [N-1:0]     joy_press,
  output logic [N-1:0]     joy_rel,
  output logic [2*N-1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // One extra count of headroom so hcnt can hold REPEAT_DELAY even when it is a power of two.
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_DELAY = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HCNT_PER   = HW'(REPEAT_PERIOD);
  localparam logic [HW-1:0] HCNT_ONE   = HW'(1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          s1, s2;
    logic          level, press, rel;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    state_t        state;
    logic          accept;

    // A change is accepted on the edge where the mismatch has lasted DEBOUNCE_CYCLES cycles.
    assign accept = (s2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        s1 <= joy_in[i];
        s2 <= s1;
        if (s2 == level) begin
          cnt <= '0;
        end else if (accept) begin
          cnt   <= '0;
          level <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        hcnt  <= '0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          IDLE: begin
            if (accept && s2) begin
              press <= 1'b1;
              hcnt  <= HCNT_ONE;
              state <= HOLD;
            end
          end
          HOLD: begin
            if (accept && !s2) begin
              rel   <= 1'b1;
              hcnt  <= '0;
              state <= IDLE;
            end else if (hcnt == HCNT_DELAY) begin
              // Masked-off channels park here with hcnt saturated until release.
              if (REPEAT_MASK[i]) begin
                press <= 1'b1;
                hcnt  <= HCNT_ONE;
                state <= REPEAT;
              end
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (accept && !s2) begin
              rel   <= 1'b1;
              hcnt  <= '0;
              state <= IDLE;
            end else if (hcnt == HCNT_PER) begin
              press <= 1'b1;
              hcnt  <= HCNT_ONE;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          default: begin
            hcnt  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end

    assign joy_level[i]         = level;
    assign joy_press[i]         = press;
    assign joy_rel[i]           = rel;
    assign fsm_state[2*i +: 2]  = state;
  end

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed bench for joy_conditioner with short debounce/repeat timing.
module tb_joy_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   joy_in;
  logic [N-1:0]   joy_level;
  logic [N-1:0]   joy_press;
  logic [N-1:0]   joy_rel;
  logic [2*N-1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3*N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rl;
  } vec_t;

  vec_t tbl[24];

  joy_conditioner #(
    .N(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .REPEAT_MASK(5'b01111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .joy_in(joy_in),
    .joy_level(joy_level), .joy_press(joy_press), .joy_rel(joy_rel),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lvl/prs/rel=%b expected %b", name, act, exp);
    end
  endtask

  // drive joy_in ahead of the next rising edge, then sample 1 time unit after it
  task automatic step(input logic [N-1:0] v);
    joy_in = v;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] d, input logic [N-1:0] l,
                              input logic [N-1:0] p, input logic [N-1:0] r);
    vec_t v;
    v.din = d; v.lvl = l; v.prs = p; v.rl = r;
    return v;
  endfunction

  initial begin
    // Edges counted from reset release; din is the value set before that edge.
    for (int k = 0; k < 5; k++) tbl[k] = mk(5'b11111, 5'b00000, 5'b00000, 5'b00000);
    tbl[5]  = mk(5'b11111, 5'b11111, 5'b11111, 5'b00000);
    tbl[6]  = mk(5'b11111, 5'b11111, 5'b00000, 5'b00000);
    for (int k = 7; k < 12; k++) tbl[k] = mk(5'b00000, 5'b11111, 5'b00000, 5'b00000);
    tbl[12] = mk(5'b00000, 5'b00000, 5'b00000, 5'b11111);
    tbl[13] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    // 3-cycle glitch on channel 0 must be rejected
    for (int k = 14; k < 17; k++) tbl[k] = mk(5'b00001, 5'b00000, 5'b00000, 5'b00000);
    for (int k = 17; k < 24; k++) tbl[k] = mk(5'b00000, 5'b00000, 5'b00000, 5'b00000);

    rst_n  = 1'b0;
    joy_in = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_outputs", {joy_level, joy_press, joy_rel}, '0);
    end
    n_checks++;
    if (fsm_state !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", fsm_state, 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      step(tbl[k].din);
      check($sformatf("table_edge%0d", k + 1), {joy_level, joy_press, joy_rel},
            {tbl[k].lvl, tbl[k].prs, tbl[k].rl});
    end

    // Auto-repeat on ch2, select (ch4, masked off) in parallel; release lands on E+30,
    // which is also a scheduled repeat edge for ch2.
    for (int t = 1; t <= 42; t++) begin
      logic [N-1:0] l, p, r;
      l = (t >= 6 && t < 36) ? 5'b10100 : 5'b00000;
      p = 5'b00000;
      if (t == 6) p = 5'b10100;
      else if (t >= 16 && t < 36 && ((t - 16) % RP) == 0) p = 5'b00100;
      r = (t == 36) ? 5'b10100 : 5'b00000;
      exp_q.push_back({l, p, r});
    end
    for (int t = 1; t <= 42; t++) begin
      logic [3*N-1:0] e;
      step((t <= 30) ? 5'b10100 : 5'b00000);
      e = exp_q.pop_front();
      check($sformatf("repeat_edge%0d", t), {joy_level, joy_press, joy_rel}, e);
    end

    // Reset mid-repeat on ch1: press at 6, repeats at 16 and 20, then async reset.
    for (int t = 1; t <= 20; t++) begin
      logic [N-1:0] l, p;
      l = (t >= 6) ? 5'b00010 : 5'b00000;
      p = (t == 6 || t == 16 || t == 20) ? 5'b00010 : 5'b00000;
      exp_q.push_back({l, p, 5'b00000});
    end
    for (int t = 1; t <= 20; t++) begin
      logic [3*N-1:0] e;
      step(5'b00010);
      e = exp_q.pop_front();
      check($sformatf("hold_edge%0d", t), {joy_level, joy_press, joy_rel}, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {joy_level, joy_press, joy_rel}, '0);
    for (int k = 0; k < 2; k++) begin
      step(5'b00010);
      check("in_reset_no_rel", {joy_level, joy_press, joy_rel}, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      logic [N-1:0] l, p;
      l = (t >= 6) ? 5'b00010 : 5'b00000;
      p = (t == 6) ? 5'b00010 : 5'b00000;
      step(5'b00010);
      check($sformatf("fresh_press_edge%0d", t), {joy_level, joy_press, joy_rel},
            {l, p, 5'b00000});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
